// File: rtl/shift_serdes_if.sv
// rtl/shift_serdes_if.sv - parallel load and receive bundle for shift_serdes
interface shift_serdes_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             rx_valid;
  logic [WIDTH-1:0] rx_data;
  logic             parity_err;

  modport master (
    output load_valid, load_data,
    input  load_ready, rx_valid, rx_data, parity_err
  );

  modport slave (
    input  load_valid, load_data,
    output load_ready, rx_valid, rx_data, parity_err
  );
endinterface

// File: rtl/shift_serdes.sv
// rtl/shift_serdes.sv - full-duplex serialiser/deserialiser with stall and frame FSM
// Optional even-parity bit appended to each frame under SHIFT_SERDES_PARITY_EN.
module shift_serdes #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst_b,
  shift_serdes_if.slave  bus,
  input  logic           en,
  input  logic           sin,
  output logic           sout,
  output logic           busy
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
`ifdef SHIFT_SERDES_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic [WIDTH-1:0] tx_shift, rx_shift;
`ifdef SHIFT_SERDES_PARITY_EN
  logic             tx_par_q, tx_par_d;
  logic             parity_err_q, parity_err_d;
`endif

  // tx drains toward the output end while rx fills from the opposite end,
  // so a loopback reproduces the loaded word in either bit order.
  always_comb begin
    if (MSB_FIRST != 0) begin
      tx_shift = {tx_q[WIDTH-2:0], 1'b0};
      rx_shift = {rx_q[WIDTH-2:0], sin};
    end else begin
      tx_shift = {1'b0, tx_q[WIDTH-1:1]};
      rx_shift = {sin, rx_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
    tx_par_d     = tx_par_q;
    parity_err_d = parity_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load_valid) begin
          tx_d    = bus.load_data;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SHIFT_SERDES_PARITY_EN
          tx_par_d = ^bus.load_data;
`endif
        end
      end
      S_SHIFT: begin
        if (en) begin
          tx_d  = tx_shift;
          rx_d  = rx_shift;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            rx_data_d = rx_shift;
`ifdef SHIFT_SERDES_PARITY_EN
            state_d = S_PARITY;
`else
            state_d    = S_DONE;
            rx_valid_d = 1'b1;
`endif
          end
        end
      end
`ifdef SHIFT_SERDES_PARITY_EN
      S_PARITY: begin
        if (en) begin
          parity_err_d = sin ^ (^rx_data_q);
          state_d      = S_DONE;
          rx_valid_d   = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= S_IDLE;
      tx_q       <= '0;
      rx_q       <= '0;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
`ifdef SHIFT_SERDES_PARITY_EN
      tx_par_q     <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
`ifdef SHIFT_SERDES_PARITY_EN
      tx_par_q     <= tx_par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    sout = 1'b1;
    case (state_q)
      S_SHIFT: sout = (MSB_FIRST != 0) ? tx_q[WIDTH-1] : tx_q[0];
`ifdef SHIFT_SERDES_PARITY_EN
      S_PARITY: sout = tx_par_q;
`endif
      default: sout = 1'b1;
    endcase
  end

  assign bus.load_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign bus.rx_valid   = rx_valid_q;
  assign bus.rx_data    = rx_data_q;
`ifdef SHIFT_SERDES_PARITY_EN
  assign bus.parity_err = parity_err_q;
`else
  assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_serdes.sv
// tb/tb_shift_serdes.sv - directed self-checking bench for shift_serdes
module tb_shift_serdes;
  localparam int W = 8;
`ifdef SHIFT_SERDES_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  shift_serdes_if #(.WIDTH(W)) bus_l ();
  shift_serdes_if #(.WIDTH(W)) bus_m ();

  logic en_l, sin_l, sout_l, busy_l, loop_l, force_l;
  logic en_m, sin_m, sout_m, busy_m, loop_m, force_m;

  assign sin_l = loop_l ? sout_l : force_l;
  assign sin_m = loop_m ? sout_m : force_m;

  shift_serdes #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_b(rst_b), .bus(bus_l), .en(en_l), .sin(sin_l), .sout(sout_l), .busy(busy_l)
  );
  shift_serdes #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_b(rst_b), .bus(bus_m), .en(en_m), .sin(sin_m), .sout(sout_m), .busy(busy_m)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge of cycle T+1, T being the handshake edge.
  task automatic load_l(input logic [7:0] d);
    bus_l.load_data  = d;
    bus_l.load_valid = 1'b1;
    @(negedge clk);
    bus_l.load_valid = 1'b0;
  endtask

  task automatic load_m(input logic [7:0] d);
    bus_m.load_data  = d;
    bus_m.load_valid = 1'b1;
    @(negedge clk);
    bus_m.load_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] seq;
    int         pulses;

    bus_l.load_valid = 1'b0; bus_l.load_data = '0;
    bus_m.load_valid = 1'b0; bus_m.load_data = '0;
    en_l = 1'b1; loop_l = 1'b1; force_l = 1'b0;
    en_m = 1'b1; loop_m = 1'b1; force_m = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_load_ready", bus_l.load_ready, 1);
    check("rst_sout", sout_l, 1);
    check("rst_busy", busy_l, 0);
    check("rst_rx_valid", bus_l.rx_valid, 0);
    check("rst_rx_data", bus_l.rx_data, 0);
    check("rst_parity_err", bus_l.parity_err, 0);
    rst_b = 1'b1;
    @(negedge clk);

    // LSB-first loopback of 0xA5
    seq = 8'b10100101;
    load_l(8'hA5);
    check("a5_load_ready_low", bus_l.load_ready, 0);
    check("a5_busy", busy_l, 1);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("a5_bit%0d", k), sout_l, seq[7-k]);
    end
    check("a5_no_early_valid", bus_l.rx_valid, 0);
    repeat (1 + PAR) @(negedge clk);
    check("a5_rx_valid", bus_l.rx_valid, 1);
    check("a5_rx_data", bus_l.rx_data, 32'hA5);
    check("a5_done_sout", sout_l, 1);
    @(negedge clk);
    check("a5_rx_valid_pulse", bus_l.rx_valid, 0);
    check("a5_load_ready_back", bus_l.load_ready, 1);

    // MSB-first loopback of 0x3C
    seq = 8'b00111100;
    load_m(8'h3C);
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("3c_bit%0d", k), sout_m, seq[7-k]);
    end
    repeat (1 + PAR) @(negedge clk);
    check("3c_rx_valid", bus_m.rx_valid, 1);
    check("3c_rx_data", bus_m.rx_data, 32'h3C);
    @(negedge clk);
    check("3c_load_ready", bus_m.load_ready, 1);

    // 0xFF with en low for three cycles after bit 2 appears
    load_l(8'hFF);
    for (int c = 1; c <= 11 + PAR; c++) begin
      if (c > 1) @(negedge clk);
      check($sformatf("ff_busy_c%0d", c), busy_l, 1);
      check($sformatf("ff_no_valid_c%0d", c), bus_l.rx_valid, 0);
      if (c >= 3 && c <= 6) check($sformatf("ff_hold_c%0d", c), sout_l, 1);
      en_l = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
    end
    @(negedge clk);
    check("ff_rx_valid", bus_l.rx_valid, 1);
    check("ff_rx_data", bus_l.rx_data, 32'hFF);
    en_l = 1'b1;
    @(negedge clk);

    // load_valid while busy is dropped
    load_l(8'h5A);
    @(negedge clk);
    bus_l.load_data  = 8'h11;
    bus_l.load_valid = 1'b1;
    @(negedge clk);
    bus_l.load_valid = 1'b0;
    repeat (6 + PAR) @(negedge clk);
    check("busy_rx_valid", bus_l.rx_valid, 1);
    check("busy_rx_data", bus_l.rx_data, 32'h5A);
    @(negedge clk);
    check("busy_load_ready", bus_l.load_ready, 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("busy_no_frame_c%0d", c), busy_l, 0);
    end
    check("busy_rx_data_kept", bus_l.rx_data, 32'h5A);

    // asynchronous reset mid-frame
    load_l(8'h33);
    repeat (3) @(negedge clk);
    rst_b = 1'b0;
    #1;
    check("abort_sout", sout_l, 1);
    check("abort_busy", busy_l, 0);
    check("abort_load_ready", bus_l.load_ready, 1);
    check("abort_rx_valid", bus_l.rx_valid, 0);
    check("abort_rx_data", bus_l.rx_data, 0);
    @(negedge clk);
    rst_b = 1'b1;
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus_l.rx_valid) pulses++;
    end
    check("abort_no_rx_valid", pulses, 0);
    check("abort_load_ready_after", bus_l.load_ready, 1);

`ifdef SHIFT_SERDES_PARITY_EN
    // 0x07 has odd weight so the even-parity bit is 1
    load_l(8'h07);
    repeat (8) @(negedge clk);
    check("par_bit", sout_l, 1);
    @(negedge clk);
    check("par_rx_valid", bus_l.rx_valid, 1);
    check("par_rx_data", bus_l.rx_data, 32'h07);
    check("par_err_clear", bus_l.parity_err, 0);
    @(negedge clk);

    load_l(8'h07);
    repeat (8) @(negedge clk);
    loop_l  = 1'b0;
    force_l = 1'b0;
    @(negedge clk);
    check("par_bad_rx_valid", bus_l.rx_valid, 1);
    check("par_err_set", bus_l.parity_err, 1);
    loop_l = 1'b1;
    @(negedge clk);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
